// File: rtl/bm_ibuf_win.sv
// bm_ibuf_win: input line buffer for the BM SAD engine.
// Narrow write words are packed into wide RAM words and stored in a circular
// buffer. A small queue of line start addresses lets the SAD datapath read any
// buffered line. Write-side space credit and read-side line readiness are
// reported to the two sides.
module bm_ibuf_win #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned PACK   = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LQ_AW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [IN_W-1:0]        din,
    output logic                   wr_rdy,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic [LQ_AW-1:0]       rd_line_sel,
    output logic [IN_W*PACK-1:0]   rd_dout,
    output logic                   rd_rdy,
    output logic [LQ_AW:0]         lines_queued,
    input  logic                   enb,
    input  logic                   start,
    input  logic                   line_end,
    input  logic                   next_line,
    input  logic [ADDR_W-1:0]      line_size,
    input  logic [8:0]             bst_len,
    input  logic [LQ_AW:0]         min_lines,
    output logic                   err_ovf,
    output logic                   err_unf
);

    localparam int unsigned RAM_W = IN_W * PACK;
    localparam int unsigned PH_W  = $clog2(PACK);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LQ_D  = 1 << LQ_AW;
    localparam int unsigned AVL_W = ADDR_W + 1;
    localparam int unsigned CNT_W = LQ_AW + 1;
    localparam int unsigned CMP_W = (AVL_W + PH_W > 9) ? (AVL_W + PH_W) : 9;

    // storage
    logic [RAM_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] lq_mem_q [LQ_D];

    // registers
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [(PACK-1)*IN_W-1:0] pack_q, pack_d;
    logic [ADDR_W-1:0]       wraddr_q, wraddr_d;
    logic [ADDR_W-1:0]       line_start_q, line_start_d;
    logic                    le_q, le_d;
    logic [LQ_AW-1:0]        head_q, head_d;
    logic [LQ_AW-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AVL_W-1:0]        avl_q, avl_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    err_unf_q, err_unf_d;
    logic [RAM_W-1:0]        rd_dout_q;

    // decoded events
    logic              wr_cmp;
    logic              wr_ok;
    logic              wr_drop;
    logic              q_full;
    logic              q_empty;
    logic              pop_ok;
    logic              pop_unf;
    logic              push_ok;
    logic              push_drop;
    logic              ram_we;
    logic [RAM_W-1:0]  wdata;
    logic [LQ_AW-1:0]  rd_ptr;
    logic [ADDR_W-1:0] raddr;
    logic [CNT_W-1:0]  min_eff;

    // shift register of the earlier words of the current RAM word, newest in LSBs
    generate
        if (PACK == 2) begin : g_pack2
            assign pack_d = din;
        end else begin : g_packn
            assign pack_d = {pack_q[(PACK-2)*IN_W-1:0], din};
        end
    endgenerate

    assign wdata = {pack_q, din};

    // event decode and next-state computation for the normal (non-clear) case
    always_comb begin
        wr_cmp       = wr && (phase_q == PH_W'(PACK - 1));
        wr_ok        = wr_cmp && (avl_q != '0);
        wr_drop      = wr_cmp && (avl_q == '0);
        q_full       = (cnt_q == CNT_W'(LQ_D));
        q_empty      = (cnt_q == '0);
        pop_ok       = next_line && !q_empty;
        pop_unf      = next_line && q_empty;
        push_ok      = le_q && (!q_full || pop_ok);
        push_drop    = le_q && q_full && !pop_ok;

        phase_d      = wr ? (phase_q + PH_W'(1)) : phase_q;
        wraddr_d     = wr_ok ? (wraddr_q + ADDR_W'(1)) : wraddr_q;
        le_d         = line_end;
        line_start_d = le_q ? wraddr_q : line_start_q;
        head_d       = pop_ok ? (head_q + LQ_AW'(1)) : head_q;
        tail_d       = push_ok ? (tail_q + LQ_AW'(1)) : tail_q;

        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        avl_d = avl_q;
        case ({wr_ok, pop_ok})
            2'b10:   avl_d = avl_q - AVL_W'(1);
            2'b01:   avl_d = avl_q + AVL_W'(line_size);
            2'b11:   avl_d = avl_q + AVL_W'(line_size) - AVL_W'(1);
            default: avl_d = avl_q;
        endcase

        err_ovf_d = err_ovf_q | wr_drop | push_drop;
        err_unf_d = err_unf_q | pop_unf;

        ram_we = enb && wr_ok && !start && !rst;
    end

    // control registers; rst and start both clear, differing only in avl
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            wraddr_q     <= '0;
            line_start_q <= '0;
            le_q         <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            avl_q        <= '0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else if (start) begin
            phase_q      <= '0;
            wraddr_q     <= '0;
            line_start_q <= '0;
            le_q         <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            avl_q        <= AVL_W'(DEPTH);
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            wraddr_q     <= wraddr_d;
            line_start_q <= line_start_d;
            le_q         <= le_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            avl_q        <= avl_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
        end
    end

    // packing shift register; contents are don't-care after clear since phase restarts
    always_ff @(posedge clk) begin
        if (wr) begin
            pack_q <= pack_d;
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[wraddr_q] <= wdata;
        end
    end

    // line-start queue write port
    always_ff @(posedge clk) begin
        if (push_ok && !start && !rst) begin
            lq_mem_q[tail_q] <= line_start_q;
        end
    end

    // read address: selected queued line start plus word offset, wrapping naturally
    always_comb begin
        rd_ptr = head_q + rd_line_sel;
        raddr  = rd_addr + lq_mem_q[rd_ptr];
    end

    // RAM read port with a single output register that holds while enb is low
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dout_q <= '0;
        end else if (enb) begin
            rd_dout_q <= mem_q[raddr];
        end
    end

    // status outputs derived from registered state
    always_comb begin
        min_eff      = (min_lines == '0) ? CNT_W'(1) : min_lines;
        wr_rdy       = ((CMP_W'(avl_q) << PH_W) >= CMP_W'(bst_len));
        rd_rdy       = (cnt_q >= min_eff);
        lines_queued = cnt_q;
        rd_dout      = rd_dout_q;
        err_ovf      = err_ovf_q;
        err_unf      = err_unf_q;
    end

endmodule

// File: tb/tb_bm_ibuf_win.sv
// Directed self-checking bench for bm_ibuf_win with default parameters.
module tb_bm_ibuf_win;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [31:0] din;
    logic        wr_rdy;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_line_sel;
    logic [63:0] rd_dout;
    logic        rd_rdy;
    logic [2:0]  lines_queued;
    logic        enb;
    logic        start;
    logic        line_end;
    logic        next_line;
    logic [9:0]  line_size;
    logic [8:0]  bst_len;
    logic [2:0]  min_lines;
    logic        err_ovf;
    logic        err_unf;

    int n_chk;
    int n_bad;

    bm_ibuf_win dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .din         (din),
        .wr_rdy      (wr_rdy),
        .rd_addr     (rd_addr),
        .rd_line_sel (rd_line_sel),
        .rd_dout     (rd_dout),
        .rd_rdy      (rd_rdy),
        .lines_queued(lines_queued),
        .enb         (enb),
        .start       (start),
        .line_end    (line_end),
        .next_line   (next_line),
        .line_size   (line_size),
        .bst_len     (bst_len),
        .min_lines   (min_lines),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] v);
        wr  = 1'b1;
        din = v;
        cyc();
        wr  = 1'b0;
    endtask

    task automatic push_line();
        line_end = 1'b1;
        cyc();
        line_end = 1'b0;
        cyc();
    endtask

    task automatic rd(input logic [1:0] sel, input logic [9:0] a);
        rd_line_sel = sel;
        rd_addr     = a;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1; wr = 1'b0; din = '0; rd_addr = '0; rd_line_sel = '0;
        enb = 1'b1; start = 1'b0; line_end = 1'b0; next_line = 1'b0;
        line_size = 10'd64; bst_len = 9'd64; min_lines = 3'd2;

        // reset state
        cyc(); cyc();
        chk("rst_wr_rdy", 64'(wr_rdy), 64'd0);
        chk("rst_rd_rdy", 64'(rd_rdy), 64'd0);
        chk("rst_lq", 64'(lines_queued), 64'd0);
        chk("rst_dout", rd_dout, 64'd0);
        chk("rst_ovf", 64'(err_ovf), 64'd0);
        chk("rst_unf", 64'(err_unf), 64'd0);
        rst = 1'b0;
        cyc();
        chk("pre_start_wr_rdy", 64'(wr_rdy), 64'd0);

        // start, first line of 128 words (values 1..128)
        do_start();
        chk("start_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("start_rd_rdy", 64'(rd_rdy), 64'd0);
        chk("start_avl", 64'(dut.avl_q), 64'd1024);
        wr_word(32'd1);
        wr_word(32'd2);
        chk("avl_after_1", 64'(dut.avl_q), 64'd1023);
        for (int k = 3; k <= 128; k++) wr_word(32'(k));
        line_end = 1'b1;
        cyc();
        line_end = 1'b0;
        chk("l1_lq_n1", 64'(lines_queued), 64'd0);
        cyc();
        chk("l1_lq_n2", 64'(lines_queued), 64'd1);
        chk("l1_rd_rdy", 64'(rd_rdy), 64'd0);
        rd(2'd0, 10'd0);
        chk("ram0", rd_dout, 64'h00000001_00000002);

        // second line (values 129..256)
        for (int k = 129; k <= 256; k++) wr_word(32'(k));
        line_end = 1'b1;
        cyc();
        line_end = 1'b0;
        chk("l2_lq_n1", 64'(lines_queued), 64'd1);
        chk("l2_rdy_n1", 64'(rd_rdy), 64'd0);
        cyc();
        chk("l2_lq_n2", 64'(lines_queued), 64'd2);
        chk("l2_rdy_n2", 64'(rd_rdy), 64'd1);
        rd(2'd1, 10'd0);
        chk("l2_word0", rd_dout, 64'h00000081_00000082);
        rd(2'd0, 10'd63);
        chk("l1_word63", rd_dout, 64'h0000007F_00000080);
        chk("avl_896", 64'(dut.avl_q), 64'd896);

        // completing write and pop in the same cycle; read uses the old head
        wr_word(32'hA0);
        wr = 1'b1; din = 32'hA1; next_line = 1'b1;
        rd_line_sel = 2'd0; rd_addr = 10'd0;
        cyc();
        wr = 1'b0; next_line = 1'b0;
        chk("pop_old_head", rd_dout, 64'h00000001_00000002);
        chk("avl_plus63", 64'(dut.avl_q), 64'd959);
        chk("pop_lq", 64'(lines_queued), 64'd1);
        chk("pop_rd_rdy", 64'(rd_rdy), 64'd0);
        rd(2'd0, 10'd0);
        chk("pop_new_head", rd_dout, 64'h00000081_00000082);
        next_line = 1'b1;
        cyc();
        chk("pop2_lq", 64'(lines_queued), 64'd0);
        chk("pop2_avl", 64'(dut.avl_q), 64'd1023);
        cyc();
        next_line = 1'b0;
        chk("unf_flag", 64'(err_unf), 64'd1);
        chk("unf_avl", 64'(dut.avl_q), 64'd1023);
        chk("unf_no_ovf", 64'(err_ovf), 64'd0);

        // queue overflow: five pushes, fifth dropped
        do_start();
        chk("clr_unf", 64'(err_unf), 64'd0);
        line_end = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        line_end = 1'b0;
        cyc(); cyc();
        chk("qfull_lq", 64'(lines_queued), 64'd4);
        chk("qfull_ovf", 64'(err_ovf), 64'd1);
        line_end = 1'b1;
        cyc();
        line_end = 1'b0; next_line = 1'b1;
        cyc();
        next_line = 1'b0;
        chk("full_pushpop_lq", 64'(lines_queued), 64'd4);
        cyc();
        chk("full_pushpop_lq2", 64'(lines_queued), 64'd4);
        chk("full_no_unf", 64'(err_unf), 64'd0);

        // fill all 1024 RAM words, then overflow one more
        do_start();
        for (int k = 0; k < 2048; k++) begin
            wr_word(32'h1000_0000 + 32'(k));
            if (k == 1983) chk("fill_rdy_avl32", 64'(wr_rdy), 64'd1);
            if (k == 1985) chk("fill_rdy_avl31", 64'(wr_rdy), 64'd0);
        end
        chk("fill_avl0", 64'(dut.avl_q), 64'd0);
        chk("fill_no_ovf", 64'(err_ovf), 64'd0);
        wr_word(32'hDEAD_0000);
        wr_word(32'hDEAD_0001);
        chk("ovf_flag", 64'(err_ovf), 64'd1);
        chk("ovf_avl", 64'(dut.avl_q), 64'd0);
        push_line();
        push_line();
        chk("ovf_lq", 64'(lines_queued), 64'd2);
        rd(2'd0, 10'd0);
        chk("ovf_ram0", rd_dout, 64'h10000000_10000001);
        rd(2'd1, 10'd0);
        chk("ovf_wraddr0", rd_dout, 64'h10000000_10000001);

        // wrap: a line starting at RAM word 1000
        do_start();
        for (int k = 0; k < 2000; k++) wr_word(32'h2000_0000 + 32'(k));
        push_line();
        line_size = 10'd1000;
        next_line = 1'b1;
        cyc();
        next_line = 1'b0;
        chk("wrap_avl", 64'(dut.avl_q), 64'd1024);
        for (int k = 2000; k < 2062; k++) wr_word(32'h2000_0000 + 32'(k));
        push_line();
        chk("wrap_lq", 64'(lines_queued), 64'd1);
        rd(2'd0, 10'd30);
        chk("wrap_ram6", rd_dout, 64'h2000080C_2000080D);
        enb = 1'b0;
        rd(2'd0, 10'd23);
        chk("enb_hold", rd_dout, 64'h2000080C_2000080D);
        enb = 1'b1;
        cyc();
        chk("wrap_ram1023", rd_dout, 64'h200007FE_200007FF);

        // start in the middle of a RAM word
        next_line = 1'b1;
        cyc(); cyc();
        next_line = 1'b0;
        chk("pre_mid_unf", 64'(err_unf), 64'd1);
        wr_word(32'h55);
        wr = 1'b1; din = 32'h66; start = 1'b1;
        cyc();
        wr = 1'b0; start = 1'b0;
        min_lines = 3'd0;
        #1;
        chk("mid_lq", 64'(lines_queued), 64'd0);
        chk("mid_unf", 64'(err_unf), 64'd0);
        chk("mid_ovf", 64'(err_ovf), 64'd0);
        chk("mid_avl", 64'(dut.avl_q), 64'd1024);
        chk("mid_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("min0_empty", 64'(rd_rdy), 64'd0);
        wr_word(32'hAAAA_0001);
        wr_word(32'hAAAA_0002);
        push_line();
        chk("min0_one", 64'(rd_rdy), 64'd1);
        rd(2'd0, 10'd0);
        chk("mid_phase0", rd_dout, 64'hAAAA0001_AAAA0002);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
